// File: rtl/cdb_arbiter.sv
// cdb_arbiter: complete-stage writeback arbiter.
// Each functional unit feeds a small circular result buffer. A round-robin
// arbiter picks one result per cycle and loads it into the output register.
// That register drives the common data bus (tag wakeup), the PRF write port
// and the ROB completion port.
// Optional build macro CDB_BYPASS_EN: an FU with an empty buffer offers its
// incoming result straight to the arbiter, which saves one cycle of latency.
// When the macro is undefined, every result goes through its buffer.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 2,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 5,
    parameter int XLEN      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    output logic [NUM_FU-1:0]          fu_ready_o,
    input  logic [NUM_FU*PREG_W-1:0]   fu_phys_reg_i,
    input  logic [NUM_FU-1:0]          fu_has_dest_i,
    input  logic [NUM_FU*XLEN-1:0]     fu_value_i,
    input  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx_i,
    output logic                       cdb_en_o,
    output logic                       cdb_tag_valid_o,
    output logic [PREG_W-1:0]          cdb_phys_reg_o,
    output logic                       prf_wr_en_o,
    output logic [PREG_W-1:0]          prf_wr_idx_o,
    output logic [XLEN-1:0]            prf_wr_data_o,
    output logic                       rob_complete_en_o,
    output logic [ROB_W-1:0]           rob_complete_idx_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_FU);

    // Entry layout, LSB first: rob_idx, value, has_dest, phys_reg.
    localparam int ENT_W   = PREG_W + 1 + XLEN + ROB_W;
    localparam int VAL_LSB = ROB_W;
    localparam int HD_BIT  = ROB_W + XLEN;
    localparam int PHY_LSB = ROB_W + XLEN + 1;

    // Per-FU views that the shared arbitration logic uses.
    logic [NUM_FU-1:0][ENT_W-1:0] in_ent;     // entry being offered on the FU port
    logic [NUM_FU-1:0][ENT_W-1:0] head_ent;   // oldest buffered entry
    logic [NUM_FU-1:0]            cnt_nz;     // buffer holds at least one entry
    logic [NUM_FU-1:0]            cand;       // arbitration candidates
    logic [NUM_FU-1:0]            gnt;        // one-hot grant
    logic [NUM_FU-1:0]            pop;        // grant is taken from the buffer head
    logic [NUM_FU-1:0]            byp_take;   // grant is taken straight from the port
    logic [NUM_FU-1:0]            push;       // port result is written into the buffer

    // Arbitration state and output register.
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_tag_q, out_tag_d;
    logic [PREG_W-1:0] out_phys_q, out_phys_d;
    logic [XLEN-1:0]   out_value_q, out_value_d;
    logic [ROB_W-1:0]  out_rob_q, out_rob_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [ENT_W-1:0]  win_ent;
    logic [IDX_W-1:0]  rr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            logic [ENT_W-1:0] mem_q [BUF_DEPTH];
            logic [PTR_W-1:0] head_q, head_d;
            logic [PTR_W-1:0] tail_q, tail_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign in_ent[gi] = {fu_phys_reg_i[gi*PREG_W +: PREG_W],
                                 fu_has_dest_i[gi],
                                 fu_value_i[gi*XLEN +: XLEN],
                                 fu_rob_idx_i[gi*ROB_W +: ROB_W]};

            assign head_ent[gi]   = mem_q[head_q];
            assign cnt_nz[gi]     = (cnt_q != '0);
            // Readiness depends only on the registered count, so a full
            // buffer stays not-ready even in a cycle where it is being popped.
            assign fu_ready_o[gi] = (cnt_q < CNT_W'(BUF_DEPTH));

            assign gnt[gi]  = win_found && (win_idx == IDX_W'(gi));
            assign pop[gi]  = gnt[gi] && cnt_nz[gi];
            assign push[gi] = fu_valid_i[gi] && fu_ready_o[gi] && !byp_take[gi];

            // Next-state for the buffer pointers and occupancy count.
            always_comb begin
                head_d = head_q;
                tail_d = tail_q;
                cnt_d  = cnt_q;
                if (push[gi]) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop[gi]) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push[gi], pop[gi]})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end

            // Buffer control registers; flush empties the buffer.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    head_q <= '0;
                    tail_q <= '0;
                    cnt_q  <= '0;
                end else if (flush_i) begin
                    head_q <= '0;
                    tail_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    head_q <= head_d;
                    tail_q <= tail_d;
                    cnt_q  <= cnt_d;
                end
            end

            // Result storage; contents are only meaningful below the count.
            always_ff @(posedge clk_i) begin
                if (push[gi] && !flush_i) begin
                    mem_q[tail_q] <= in_ent[gi];
                end
            end
        end
    endgenerate

`ifdef CDB_BYPASS_EN
    // An empty buffer lets its live port result compete directly.
    assign cand     = cnt_nz | fu_valid_i;
    assign byp_take = gnt & ~cnt_nz;
`else
    assign cand     = cnt_nz;
    assign byp_take = '0;
`endif

    // Round-robin search: first candidate at or after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!win_found && cand[(int'(rr_q) + k) % NUM_FU]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_q) + k) % NUM_FU);
            end
        end
    end

    // Winner's payload: the buffer head, or the port result on a bypass win.
    always_comb begin
        win_ent = head_ent[win_idx];
        if (byp_take[win_idx]) begin
            win_ent = in_ent[win_idx];
        end
    end

    assign rr_next = (win_idx == IDX_W'(NUM_FU - 1)) ? '0 : win_idx + IDX_W'(1);

    // Next-state for the output register; payload holds when idle.
    always_comb begin
        out_valid_d = win_found;
        out_tag_d   = 1'b0;
        out_phys_d  = out_phys_q;
        out_value_d = out_value_q;
        out_rob_d   = out_rob_q;
        rr_d        = rr_q;
        if (win_found) begin
            out_phys_d  = win_ent[PHY_LSB +: PREG_W];
            out_value_d = win_ent[VAL_LSB +: XLEN];
            out_rob_d   = win_ent[ROB_W-1:0];
            // Physical register 0 is never woken up or written.
            out_tag_d   = win_ent[HD_BIT] && (win_ent[PHY_LSB +: PREG_W] != '0);
            rr_d        = rr_next;
        end
    end

    // Broadcast register and round-robin pointer; flush squashes both.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            out_phys_q  <= '0;
            out_value_q <= '0;
            out_rob_q   <= '0;
        end else if (flush_i) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            out_phys_q  <= '0;
            out_value_q <= '0;
            out_rob_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_phys_q  <= out_phys_d;
            out_value_q <= out_value_d;
            out_rob_q   <= out_rob_d;
        end
    end

    assign cdb_en_o           = out_valid_q;
    assign cdb_tag_valid_o    = out_tag_q;
    assign cdb_phys_reg_o     = out_phys_q;
    assign prf_wr_en_o        = out_tag_q;
    assign prf_wr_idx_o       = out_phys_q;
    assign prf_wr_data_o      = out_value_q;
    assign rob_complete_en_o  = out_valid_q;
    assign rob_complete_idx_o = out_rob_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter. Each FU has a pending-result queue.
// Accepted results move into a per-FU expected queue, and every broadcast is
// popped from the queue of the FU named in value[31:28].
module tb_cdb_arbiter;
    localparam int NUM_FU    = 4;
    localparam int BUF_DEPTH = 2;
    localparam int PREG_W    = 6;
    localparam int ROB_W     = 5;
    localparam int XLEN      = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [PREG_W-1:0] phys;
        logic              has_dest;
        logic [XLEN-1:0]   value;
        logic [ROB_W-1:0]  rob;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [NUM_FU-1:0]        fu_valid = '0;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU*PREG_W-1:0] fu_phys_reg = '0;
    logic [NUM_FU-1:0]        fu_has_dest = '0;
    logic [NUM_FU*XLEN-1:0]   fu_value = '0;
    logic [NUM_FU*ROB_W-1:0]  fu_rob_idx = '0;
    logic                     cdb_en, cdb_tag_valid, prf_wr_en, rob_complete_en;
    logic [PREG_W-1:0]        cdb_phys_reg, prf_wr_idx;
    logic [XLEN-1:0]          prf_wr_data;
    logic [ROB_W-1:0]         rob_complete_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    res_t pend_q [NUM_FU][$];
    res_t exp_q  [NUM_FU][$];
    int   gseq[$];
    int   gcyc[$];
    logic [NUM_FU-1:0] acc;

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH), .PREG_W(PREG_W),
        .ROB_W(ROB_W), .XLEN(XLEN)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
        .fu_phys_reg_i(fu_phys_reg), .fu_has_dest_i(fu_has_dest),
        .fu_value_i(fu_value), .fu_rob_idx_i(fu_rob_idx),
        .cdb_en_o(cdb_en), .cdb_tag_valid_o(cdb_tag_valid),
        .cdb_phys_reg_o(cdb_phys_reg), .prf_wr_en_o(prf_wr_en),
        .prf_wr_idx_o(prf_wr_idx), .prf_wr_data_o(prf_wr_data),
        .rob_complete_en_o(rob_complete_en), .rob_complete_idx_o(rob_complete_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int i = 0; i < NUM_FU; i++) s += pend_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    task automatic enq(input int fu, input logic [PREG_W-1:0] phys, input logic hd,
                       input logic [15:0] seq, input logic [ROB_W-1:0] rob);
        res_t r;
        logic [3:0] id;
        id = 4'(fu);
        r.phys = phys;
        r.has_dest = hd;
        r.value = {id, 12'h000, seq};
        r.rob = rob;
        pend_q[fu].push_back(r);
    endtask

    // FU model: holds its head result until it is accepted.
    initial begin
        forever begin
            @(negedge clk);
            acc = fu_valid & fu_ready & {NUM_FU{~flush & ~rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i] && pend_q[i].size() > 0) exp_q[i].push_back(pend_q[i].pop_front());
                if (pend_q[i].size() > 0) begin
                    fu_valid[i] = 1'b1;
                    fu_phys_reg[i*PREG_W +: PREG_W] = pend_q[i][0].phys;
                    fu_has_dest[i] = pend_q[i][0].has_dest;
                    fu_value[i*XLEN +: XLEN] = pend_q[i][0].value;
                    fu_rob_idx[i*ROB_W +: ROB_W] = pend_q[i][0].rob;
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: compares each broadcast against the scoreboard.
    always @(negedge clk) begin
        int id;
        res_t e;
        logic exp_tv;
        if (!rst) begin
            if (cdb_en) begin
                id = int'(prf_wr_data[31:28]);
                if (id >= NUM_FU || exp_q[id].size() == 0) begin
                    chk("spurious_bcast", cdb_en, 1'b0);
                end else begin
                    e = exp_q[id].pop_front();
                    exp_tv = e.has_dest && (e.phys != '0);
                    $display("bcast fu%0d phys=%0d data=0x%0h rob=%0d tag=%0b", id,
                             cdb_phys_reg, prf_wr_data, rob_complete_idx, cdb_tag_valid);
                    chk("cdb_phys", cdb_phys_reg, e.phys);
                    chk("prf_idx", prf_wr_idx, e.phys);
                    chk("prf_data", prf_wr_data, e.value);
                    chk("rob_idx", rob_complete_idx, e.rob);
                    chk("tag_valid", cdb_tag_valid, exp_tv);
                    chk("prf_wr_en", prf_wr_en, exp_tv);
                    chk("rob_en", rob_complete_en, 1'b1);
                    gseq.push_back(id);
                    gcyc.push_back(cyc);
                end
            end else begin
                chk("idle_outputs", {cdb_tag_valid, prf_wr_en, rob_complete_en}, 3'b000);
            end
        end
    end

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (outstanding() != 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #2;
        chk(tag, outstanding(), 0);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_FU; i++) begin
            pend_q[i].delete();
            exp_q[i].delete();
        end
        gseq.delete();
        gcyc.delete();
    endtask

    // Squash: called at posedge+2, returns at posedge+2 after the flush edge.
    task automatic do_flush();
        flush = 1'b1;
        for (int i = 0; i < NUM_FU; i++) pend_q[i].delete();
        @(posedge clk); #2;
        flush = 1'b0;
        clear_queues();
        chk("flush_cdb_en", cdb_en, 1'b0);
        chk("flush_ready", fu_ready, {NUM_FU{1'b1}});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_cdb_en", cdb_en, 1'b0);
        chk("rst_tag_valid", cdb_tag_valid, 1'b0);
        chk("rst_prf_en", prf_wr_en, 1'b0);
        chk("rst_rob_en", rob_complete_en, 1'b0);
        chk("rst_cdb_phys", cdb_phys_reg, 0);
        chk("rst_prf_idx", prf_wr_idx, 0);
        chk("rst_prf_data", prf_wr_data, 0);
        chk("rst_rob_idx", rob_complete_idx, 0);
        chk("rst_ready", fu_ready, {NUM_FU{1'b1}});
        @(posedge clk); #2;

        // Single result on FU0: latency and one-cycle pulse
        enq(0, 6'd33, 1'b1, 16'h1234, 5'd3);
        @(posedge clk);
        @(posedge clk); #2;
        chk("lat_edge1", cdb_en, BYPASS);
        @(posedge clk); #2;
        chk("lat_edge2", cdb_en, !BYPASS);
        @(posedge clk); #2;
        chk("lat_edge3", cdb_en, 1'b0);
        drain("single_drain", 10);

        // All four FUs at once from rr_ptr 0
        do_flush();
        for (int i = 0; i < NUM_FU; i++) enq(i, 6'(10 + i), 1'b1, 16'(i), 5'(i));
        drain("rr_drain", 20);
        chk("rr_count", gseq.size(), NUM_FU);
        if (gseq.size() == NUM_FU) begin
            for (int k = 0; k < NUM_FU; k++) chk("rr_order", gseq[k], k);
            chk("rr_back_to_back", gcyc[NUM_FU-1] - gcyc[0], NUM_FU - 1);
        end

        // FU2 streams every cycle
        do_flush();
        for (int k = 0; k < 10; k++) enq(2, 6'($urandom_range(1, 63)), 1'b1, 16'(k), 5'($urandom_range(0, 31)));
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #2;
            chk("stream_ready2", fu_ready[2], 1'b1);
        end
        drain("stream_drain", 10);
        chk("stream_count", gseq.size(), 10);
        if (gseq.size() == 10) chk("stream_rate", gcyc[9] - gcyc[0], 9);

        // FU0 backlog against three back-to-back FU1 results
        do_flush();
        for (int k = 0; k < 6; k++) enq(0, 6'(20 + k), 1'b1, 16'(k), 5'(k));
        for (int k = 0; k < 3; k++) enq(1, 6'(40 + k), 1'b1, 16'(k), 5'(16 + k));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        chk("fu1_ready_after2", fu_ready[1], BYPASS);
        drain("alt_drain", 30);
        chk("alt_count", gseq.size(), 9);
        for (int k = 0; k < 6 && k < gseq.size(); k++) chk("alt_grant", gseq[k], k % 2);

        // No-destination and phys 0 results still complete in the ROB
        do_flush();
        enq(3, 6'd0, 1'b1, 16'h00aa, 5'd7);
        enq(1, 6'd21, 1'b0, 16'h00bb, 5'd7);
        drain("nodest_drain", 10);
        chk("nodest_count", gseq.size(), 2);

        // Flush with results buffered
        do_flush();
        for (int i = 0; i < NUM_FU; i++)
            for (int k = 0; k < 3; k++) enq(i, 6'(1 + 8*i + k), 1'b1, 16'(k), 5'(k));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_flush_backlog", outstanding() >= 3, 1'b1);
        do_flush();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            chk("post_flush_idle", cdb_en, 1'b0);
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < NUM_FU; i++)
            for (int k = 0; k < 3; k++) enq(i, 6'(2 + 8*i + k), 1'b1, 16'(k), 5'(k + 8));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_reset_backlog", outstanding() >= 3, 1'b1);
        rst = 1'b1;
        clear_queues();
        #1;
        chk("async_rst_cdb_en", cdb_en, 1'b0);
        chk("async_rst_rob_en", rob_complete_en, 1'b0);
        chk("async_rst_data", prf_wr_data, 0);
        chk("async_rst_ready", fu_ready, {NUM_FU{1'b1}});
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            chk("post_reset_idle", cdb_en, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
